// File: rtl/gate_model_bist.sv
// BIST harness for combinational gate models.
// Drives LFSR or counting stimulus, compacts the response into a MISR and compares it against a golden signature.
module gate_model_bist #(
  parameter int               N_IN      = 19,
  parameter int               N_OUT     = 10,
  parameter int               PATTERNS  = 300,
  parameter logic [N_IN-1:0]  LFSR_TAPS = 19'h40027,
  parameter logic [N_IN-1:0]  LFSR_SEED = 19'h00001,
  parameter logic [N_OUT-1:0] MISR_TAPS = 10'h204,
  parameter int               CW        = $clog2(PATTERNS+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [N_OUT-1:0] golden,
  input  logic [N_OUT-1:0] dut_out,
  output logic [N_IN-1:0]  dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] signature,
  output logic [CW-1:0]    pat_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [N_IN-1:0] IN_ONE   = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_LAST = CW'(PATTERNS-1);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [N_IN-1:0] SEED_EFF = (LFSR_SEED == '0) ? IN_ONE : LFSR_SEED;

  state_t           state;
  logic             mode_q;
  logic [N_OUT-1:0] sig_next;
  logic [N_IN-1:0]  lfsr_next;
  logic [N_IN-1:0]  stim_next;

  assign sig_next  = {signature[N_OUT-2:0], ^(signature & MISR_TAPS)} ^ dut_out;
  assign lfsr_next = {dut_in[N_IN-2:0], ^(dut_in & LFSR_TAPS)};
  assign stim_next = mode_q ? (dut_in + IN_ONE) : lfsr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
      pat_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // abort outranks start and always lands in IDLE.
          if (abort) begin
            state <= IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else if (start) begin
            state     <= RUN;
            mode_q    <= mode;
            dut_in    <= mode ? '0 : SEED_EFF;
            signature <= '0;
            pat_count <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            signature <= sig_next;
            dut_in    <= stim_next;
            pat_count <= pat_count + CNT_ONE;
            if (pat_count == CNT_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_next == golden);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule
